sevenseg_scanner: RTL and testbench

Four-digit multiplexed seven-segment display driver for the board's common-anode display. It sits directly downstream of the processor's 16-bit `result` bus in the `machine` top level. It captures the value on a load strobe and double-buffers it so that a frame is never torn mid-scan. It decodes each nibble to hexadecimal segment patterns and scans the anodes, with a blanking gap between digits to suppress ghosting.

---
 rtl/disp_pkg.sv | 31 +++
 rtl/hex7seg.sv | 19 +
 rtl/sevenseg_scanner.sv | 144 ++++++++++++++
 tb/tb_sevenseg_scanner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : disp_pkg
// Purpose : Shared constants for the multiplexed seven-segment display path:
//           hex segment patterns, blank/off codes, digit count and the
//           scanner state encoding.
// Ports   : (package - none)
// Rev     : 1.0  initial release
// ============================================================================
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low codes: all segments dark, all anodes off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low segment patterns ordered {g,f,e,d,c,b,a}, indexed by nibble.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Scanner state encoding.
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module  : hex7seg
// Purpose : Combinational nibble to active-low seven-segment decoder.
// Ports   : nibble [3:0] in  - hexadecimal digit
//           seg7   [6:0] out - active-low cathodes {g,f,e,d,c,b,a}
// Rev     : 1.0  initial release
// ============================================================================
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  assign seg7 = SEG_HEX[nibble];

endmodule
`default_nettype wire

// File: rtl/sevenseg_scanner.sv
`default_nettype none
// ============================================================================
// Module  : sevenseg_scanner
// Purpose : Four-digit multiplexed common-anode seven-segment driver.
//           Captures a 16-bit value on a load strobe, double-buffers it so a
//           frame is never torn, and scans the digits with a blanking gap at
//           the start of every digit slot to suppress ghosting.
// Ports   : clk          in      - system clock, rising edge
//           rst_n        in      - asynchronous active-low reset
//           value [15:0] in      - value to display, nibble k -> digit k
//           load         in      - single-cycle capture strobe for value
//           dp_en [3:0]  in      - per-digit decimal point enable (live)
//           an    [3:0]  out     - anode enables, active low
//           seg   [7:0]  out     - cathodes, active low, {dp,g,f,e,d,c,b,a}
//           frame_start  out     - one-cycle pulse as digit 0's slot begins
// Rev     : 1.0  initial release
// ============================================================================
module sevenseg_scanner
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int              SLOT_W     = $clog2(REFRESH_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [1:0]      DIGIT_LAST = 2'(NUM_DIGITS - 1);
  // With no blanking gap every slot starts directly in DRIVE.
  localparam logic [0:0]      ST_SLOT_START = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        digit_q, digit_d;
  logic [0:0]        state_q, state_d;
  logic [15:0]       pending_q, pending_d;
  logic [15:0]       shown_q, shown_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_start_q, frame_start_d;

  logic              slot_wrap;
  logic              frame_wrap;
  logic [3:0]        nibble;
  logic [6:0]        seg7;
  logic              suppress;

  // --------------------------------------------------------------------------
  // Counters and double buffer
  // --------------------------------------------------------------------------
  always_comb begin
    slot_wrap  = (slot_q == SLOT_LAST);
    frame_wrap = slot_wrap && (digit_q == DIGIT_LAST);
    slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d    = slot_wrap ? digit_q + 2'd1 : digit_q;
    pending_d  = load ? value : pending_q;
    // pending_d already carries value on a coincident load, so the new frame
    // picks it up directly.
    shown_d    = frame_wrap ? pending_d : shown_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      digit_q   <= 2'd0;
      pending_q <= 16'd0;
      shown_q   <= 16'd0;
    end else begin
      slot_q    <= slot_d;
      digit_q   <= digit_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SLOT_START;
    end else begin
      state_q <= state_d;
    end
  end

  // state_q tracks (slot_q < BLANK_CYCLES) by construction.
  always_comb begin
    state_d = state_q;
    if (slot_wrap) begin
      state_d = ST_SLOT_START;
    end else if (slot_d == SLOT_BLANK_END) begin
      state_d = ST_DRIVE;
    end
  end

  assign nibble = shown_q[{digit_q, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg7   (seg7)
  );

  always_comb begin
    // A digit is a leading zero when it and every more significant nibble
    // are zero; digit 0 always stays lit.
    suppress      = (LZ_SUPPRESS != 0) && (digit_q != 2'd0) &&
                    ((shown_q >> {digit_q, 2'b00}) == 16'd0);
    an_d          = AN_OFF;
    seg_d         = SEG_BLANK;
    frame_start_d = (slot_q == '0) && (digit_q == 2'd0);
    if ((state_q == ST_DRIVE) && !suppress) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = {~dp_en[digit_q], seg7};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_sevenseg_scanner
// Purpose : Self-checking bench for sevenseg_scanner. Two instances share all
//           inputs, one without and one with leading-zero suppression; both
//           are compared every cycle against a frame-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sevenseg_scanner;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_en;
  logic [3:0]  an_a, an_b;
  logic [7:0]  seg_a, seg_b;
  logic        fs_a, fs_b;

  int          checks;
  int          errors;

  // Reference model state: cycles since reset release, plus both buffers.
  int          n;
  logic [15:0] shown_m;
  logic [15:0] pending_m;

  sevenseg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(0)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .load        (load),
    .dp_en       (dp_en),
    .an          (an_a),
    .seg         (seg_a),
    .frame_start (fs_a)
  );

  sevenseg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .load        (load),
    .dp_en       (dp_en),
    .an          (an_b),
    .seg         (seg_b),
    .frame_start (fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  // Expected {an, seg} for the counter position reached after t cycles.
  function automatic logic [11:0] exp_out(int t, logic [15:0] sh, logic [3:0] dp, bit lz);
    int          slot;
    int          dig;
    logic [15:0] upper;
    logic [3:0]  an_e;
    slot  = t % RD;
    dig   = (t / RD) % 4;
    upper = sh >> (4 * dig);
    if (slot < BC) return {4'hF, 8'hFF};
    if (lz && dig > 0 && upper == 16'd0) return {4'hF, 8'hFF};
    an_e = ~(4'b0001 << dig);
    return {an_e, ~dp[dig], HEX_TAB[sh[4*dig +: 4]]};
  endfunction

  // One clock: predict, clock, compare, advance the model. load is a pulse.
  task automatic step();
    logic [11:0] ea;
    logic [11:0] eb;
    logic        efs;
    ea  = exp_out(n, shown_m, dp_en, 1'b0);
    eb  = exp_out(n, shown_m, dp_en, 1'b1);
    efs = (n % FRAME == 0);
    @(posedge clk);
    #1;
    check("an_a",  {12'd0, an_a},  {12'd0, ea[11:8]});
    check("seg_a", {8'd0, seg_a},  {8'd0, ea[7:0]});
    check("an_b",  {12'd0, an_b},  {12'd0, eb[11:8]});
    check("seg_b", {8'd0, seg_b},  {8'd0, eb[7:0]});
    check("fs_a",  {15'd0, fs_a},  {15'd0, efs});
    check("fs_b",  {15'd0, fs_b},  {15'd0, efs});
    if (n % FRAME == FRAME - 1) shown_m = load ? value : pending_m;
    if (load) pending_m = value;
    n++;
    load = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
  endtask

  initial begin
    int target;
    checks    = 0;
    errors    = 0;
    n         = 0;
    shown_m   = 16'd0;
    pending_m = 16'd0;
    rst_n     = 1'b0;
    load      = 1'b0;
    value     = 16'd0;
    dp_en     = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_an",  {12'd0, an_a},  16'h000F);
    check("rst_seg", {8'd0, seg_a},  16'h00FF);
    check("rst_fs",  {15'd0, fs_a},  16'h0000);
    check("rst_anb", {12'd0, an_b},  16'h000F);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 1234 on the first cycle; current frame still shows zeros.
    do_load(16'h1234);
    run_to(2);
    step();
    check("frame0_zero", {8'd0, seg_a}, 16'h00C0);
    run_to(FRAME + 2);
    step();
    check("d0_is_4",  {8'd0, seg_a}, 16'h0099);
    check("d0_an",    {12'd0, an_a}, 16'h000E);

    // Tear-free: load during digit 2 of frame 2.
    run_to(2 * FRAME + 2 * RD + 3);
    do_load(16'hABCD);
    run_to(2 * FRAME + 3 * RD + 2);
    step();
    check("tear_d3_old", {8'd0, seg_a}, 16'h00F9);
    run_to(3 * FRAME + 2);
    step();
    check("tear_d0_D", {8'd0, seg_a}, 16'h00A1);

    // Coincident load on the digit 3 -> 0 wrap.
    run_to(4 * FRAME - 1);
    do_load(16'h00F0);
    run_to(4 * FRAME + RD + 2);
    step();
    check("coinc_d1_F", {8'd0, seg_a}, 16'h008E);
    check("coinc_d1_an", {12'd0, an_a}, 16'h000D);
    run_to(4 * FRAME + 3 * RD + 2);
    step();
    check("lz_d3_off", {12'd0, an_b}, 16'h000F);

    // Leading-zero suppression on 0050, then on 0000.
    do_load(16'h0050);
    run_to(5 * FRAME + 2);
    step();
    check("lz_d0_0", {8'd0, seg_b}, 16'h00C0);
    run_to(5 * FRAME + RD + 2);
    step();
    check("lz_d1_5", {8'd0, seg_b}, 16'h0092);
    run_to(5 * FRAME + 2 * RD + 4);
    step();
    check("lz_d2_off", {12'd0, an_b}, 16'h000F);
    do_load(16'h0000);
    run_to(6 * FRAME + RD + 2);
    step();
    check("lz_zero_d1", {12'd0, an_b}, 16'h000F);

    // Decimal points on digits 0 and 2 with 8888.
    dp_en = 4'b0101;
    do_load(16'h8888);
    run_to(7 * FRAME + 2);
    step();
    check("dp_d0", {8'd0, seg_a}, 16'h0000);
    run_to(7 * FRAME + RD + 2);
    step();
    check("dp_d1", {8'd0, seg_a}, 16'h0080);
    dp_en = 4'd0;

    // Randomized traffic, with leading zeros injected for the LZ instance.
    for (int i = 0; i < 320; i++) begin
      value = 16'($urandom) >> (4 * $urandom_range(3, 0));
      load  = ($urandom_range(7, 0) == 0);
      dp_en = 4'($urandom);
      step();
    end
    dp_en = 4'd0;

    // Asynchronous reset while digit 2 is driven.
    target = ((n / FRAME) + 1) * FRAME + 2 * RD + 3;
    run_to(target);
    step();
    check("pre_rst_an", {12'd0, an_a}, 16'h000B);
    rst_n = 1'b0;
    #1;
    check("arst_an",  {12'd0, an_a},  16'h000F);
    check("arst_seg", {8'd0, seg_a},  16'h00FF);
    check("arst_anb", {12'd0, an_b},  16'h000F);
    @(negedge clk);
    rst_n     = 1'b1;
    n         = 0;
    shown_m   = 16'd0;
    pending_m = 16'd0;
    step();
    check("post_rst_fs", {15'd0, fs_a}, 16'h0001);
    run_to(2);
    step();
    check("post_rst_zero", {8'd0, seg_a}, 16'h00C0);
    run_to(FRAME + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
